auth_uart_rx: RTL and testbench
===============================

Name: auth_uart_rx

Overview:
- Consumes the serial command stream that the bench's UART_tx (standing in for the BLE module) drives onto the Segway RX pin.
- Deserializes 8N1 bytes and runs the rider-authorization FSM that gates power to the balance/motor logic.
- Asserts pwr_up after a 'g' (0x67).
- Deasserts pwr_up after an 's' (0x73) once the rider is off.

Parameters:
BAUD_CNT, 2604, clocks per bit (50 MHz / 19200 baud); must be even and >= 16.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
RX  in  1  serial input, idle high, unsynchronized
rider_off  in  1  high when load cells report no rider (synchronous to clk)
rx_data  out  8  last correctly framed byte
rdy  out  1  one-cycle pulse: new byte valid on rx_data
frm_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
pwr_up  out  1  authorization to power the drive

Behaviour:
- Clock and reset (decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: rx_data=0x00, rdy=0, frm_err=0, pwr_up=0. RX synchronizer flops preset to 1. Receiver in IDLE, auth FSM in OFF.
- RX synchronizer: RX passes through a 2-flop synchronizer. All decisions use the synced value.
- Receiver FSM, IDLE:
  - A synced falling edge enters RECV.
  - On entry: baud counter loads BAUD_CNT/2, bit counter loads 0.
- Receiver FSM, RECV:
  - The baud counter decrements each clock.
  - At zero, sample RX into a 10-bit shift register (LSB-first, start bit first), increment the bit counter, and reload BAUD_CNT.
  - After the 10th sample, return to IDLE.
  - If the stop bit is 1: on the next clock, rx_data <= data bits and rdy pulses for exactly 1 cycle.
  - If the stop bit is 0: frm_err pulses for 1 cycle, and rx_data and rdy are untouched.
- Back-to-back bytes: a new start edge is accepted on the first cycle back in IDLE.
- Latency: rdy rises between 9.5*BAUD_CNT+2 and 9.5*BAUD_CNT+5 clocks after the RX falling edge.
- Auth FSM (Moore; pwr_up = state != OFF, registered):
  - OFF: rdy && rx_data==0x67 -> PWRD.
  - PWRD: rdy && rx_data==0x73 -> OFF if rider_off, else DSCN.
  - DSCN: rider_off -> OFF. Otherwise rdy && rx_data==0x67 -> PWRD. rider_off has priority if both occur in the same cycle.
  - Any other byte, or a frm_err: no transition.
  - 'g' while in PWRD: stays PWRD. 's' while in OFF: stays OFF.
- pwr_up timing: pwr_up changes on the clock edge after the cycle in which rdy, or rider_off in DSCN, is sampled.
- rider_off in PWRD: ignored. Dismounting alone never removes power without 's'.
- Reset mid-byte: receiver aborts immediately. The next complete frame is received normally, with no partial-frame residue.

Optional Feature:
- Macro: RX_GLITCH_FILTER_EN.
- Defined:
  - The start bit is re-checked at its mid-bit sample.
  - If the synced RX is 1 there, the receiver returns to IDLE with no rdy or frm_err. This rejects pulses shorter than BAUD_CNT/2.
- Undefined:
  - Every falling edge starts a frame unconditionally.
  - The start sample is shifted in but not checked.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 for 5 clocks with RX=1.
  - Response: rx_data=0x00, rdy=0, frm_err=0, pwr_up=0. All hold for 20000 idle clocks after release.
- Go command:
  - Stimulus: UART_tx sends 0x67.
  - Response: single-cycle rdy within the latency window, rx_data=0x67, pwr_up=1 one clock later.
- Stop with rider on:
  - Stimulus: pwr_up=1, rider_off=0, send 0x73.
  - Response: rdy with rx_data=0x73 and pwr_up stays 1 (DSCN).
  - Follow-up: drive rider_off=1; pwr_up=0 on the next clock.
- Stop with rider off:
  - Stimulus: pwr_up=1, rider_off=1, send 0x73.
  - Response: pwr_up=0 one clock after rdy.
- Irrelevant bytes and framing errors:
  - Stimulus (irrelevant byte): in OFF, send 0x41.
  - Response: rdy with rx_data=0x41, pwr_up stays 0.
  - Stimulus (framing error): hand-drive frame 0x67 with stop bit 0.
  - Response: frm_err pulse, no rdy, rx_data stays 0x41, pwr_up stays 0.
- Reset mid-byte and glitch:
  - Stimulus (reset mid-byte): assert rst_n after 4 bits of 0x67, then send a full 0x67.
  - Response: one rdy, rx_data=0x67, pwr_up=1.
  - Stimulus (glitch, with RX_GLITCH_FILTER_EN): 400-clock low pulse on RX.
  - Response: no rdy, no frm_err.

Source files
------------

// File: rtl/auth_uart_rx.sv
// auth_uart_rx
// ------------
// 8N1 UART receiver plus the rider-authorization FSM that gates drive power.
// A 'g' (0x67) powers the drive up. An 's' (0x73) powers it down, but only
// once the load cells report that the rider is off.
//
// Parameters:
//   BAUD_CNT  clocks per bit (even, >= 16); 2604 = 50 MHz / 19200 baud
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   RX         serial input, idle high, asynchronous to clk
//   rider_off  high when no rider is on the platform (synchronous to clk)
//   rx_data    last correctly framed byte
//   rdy        one-cycle pulse: new byte valid on rx_data
//   frm_err    one-cycle pulse: stop bit sampled low, byte discarded
//   pwr_up     authorization to power the drive
//
// Build option:
//   RX_GLITCH_FILTER_EN  When defined, the start bit is re-checked at its
//                        mid-bit sample. A start bit that has already returned
//                        high sends the receiver back to idle, so low pulses
//                        shorter than BAUD_CNT/2 are dropped silently.

module auth_uart_rx #(
  parameter int BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam int CW = $clog2(BAUD_CNT + 1);
  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic [1:0] {AUTH_OFF, AUTH_PWRD, AUTH_DSCN} auth_state_t;

  // Synchronizer and edge-detect history. These preset to 1 (the idle line
  // level), so releasing reset does not create a false start edge.
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

  rx_state_t   rx_state_reg, rx_state_next;
  logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [9:0]  shift_reg, shift_next;
  logic        done_reg, done_next;

  logic [7:0]  rx_data_reg;
  logic        rdy_reg, frm_err_reg;

  auth_state_t auth_state_reg, auth_state_next;
  logic        pwr_up_reg;

  // The start bit sits in shift_reg[0]. It is never used to qualify a frame.
  logic start_bit_unused;
  assign start_bit_unused = shift_reg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // The receiver state register. Reset also aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      done_reg     <= done_next;
    end
  end

  // The baud counter counts down, and a sample is taken on the clock where
  // it would reach zero. The first sample therefore lands BAUD_CNT/2 clocks
  // after the detected edge (mid start bit), and every later sample lands
  // exactly BAUD_CNT clocks after the one before.
  always_comb begin
    rx_state_next = rx_state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    done_next     = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = RX_RECV;
          baud_cnt_next = CW'(BAUD_CNT / 2);
          bit_cnt_next  = 4'd0;
        end
      end
      RX_RECV: begin
        if (baud_cnt_reg == CW'(1)) begin
          shift_next    = {rx_sync_reg, shift_reg[9:1]};
          bit_cnt_next  = bit_cnt_reg + 4'd1;
          baud_cnt_next = CW'(BAUD_CNT);
`ifdef RX_GLITCH_FILTER_EN
          if (bit_cnt_reg == 4'd0 && rx_sync_reg) begin
            rx_state_next = RX_IDLE;
          end else if (bit_cnt_reg == 4'd9) begin
            rx_state_next = RX_IDLE;
            done_next     = 1'b1;
          end
`else
          if (bit_cnt_reg == 4'd9) begin
            rx_state_next = RX_IDLE;
            done_next     = 1'b1;
          end
`endif
        end else begin
          baud_cnt_next = baud_cnt_reg - CW'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // A frame is checked one clock after its stop sample. shift_reg cannot
  // change during that clock, because a new start edge only loads the
  // counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg <= 8'h00;
      rdy_reg     <= 1'b0;
      frm_err_reg <= 1'b0;
    end else begin
      rdy_reg     <= 1'b0;
      frm_err_reg <= 1'b0;
      if (done_reg) begin
        if (shift_reg[9]) begin
          rx_data_reg <= shift_reg[8:1];
          rdy_reg     <= 1'b1;
        end else begin
          frm_err_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth_state_reg <= AUTH_OFF;
      pwr_up_reg     <= 1'b0;
    end else begin
      auth_state_reg <= auth_state_next;
      pwr_up_reg     <= (auth_state_next != AUTH_OFF);
    end
  end

  always_comb begin
    auth_state_next = auth_state_reg;
    case (auth_state_reg)
      AUTH_OFF: begin
        if (rdy_reg && rx_data_reg == CMD_GO) auth_state_next = AUTH_PWRD;
      end
      AUTH_PWRD: begin
        // rider_off alone is ignored here: only an 's' can remove power.
        if (rdy_reg && rx_data_reg == CMD_STOP)
          auth_state_next = rider_off ? AUTH_OFF : AUTH_DSCN;
      end
      AUTH_DSCN: begin
        if (rider_off)                             auth_state_next = AUTH_OFF;
        else if (rdy_reg && rx_data_reg == CMD_GO) auth_state_next = AUTH_PWRD;
      end
      default: auth_state_next = AUTH_OFF;
    endcase
  end

  assign rx_data = rx_data_reg;
  assign rdy     = rdy_reg;
  assign frm_err = frm_err_reg;
  assign pwr_up  = pwr_up_reg;

endmodule

// File: tb/tb_auth_uart_rx.sv
// tb_auth_uart_rx
// ---------------
// Directed bench for auth_uart_rx. A UART transmitter task stands in for the
// BLE module. A negedge monitor records rdy and frm_err pulses, rx_data, and
// pwr_up around each rdy pulse.

module tb_auth_uart_rx;

  localparam int B   = 820;                     // B/2 > 400 for the glitch test
  localparam int LAT_LO = (19 * B) / 2 + 2;
  localparam int LAT_HI = (19 * B) / 2 + 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err, pwr_up;

  auth_uart_rx #(.BAUD_CNT(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .rider_off(rider_off),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .pwr_up(pwr_up)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  int         rdy_count = 0;
  int         frm_count = 0;
  int         rdy_cyc = 0;
  int         start_cyc = 0;
  logic [7:0] data_at_rdy = 8'h00;
  logic       pwr_at_rdy = 1'b0;
  logic       pwr_after = 1'b0;
  logic       prev_rdy = 1'b0;

  always @(negedge clk) begin
    if (prev_rdy) pwr_after = pwr_up;
    prev_rdy = rdy;
    if (rdy) begin
      rdy_count   = rdy_count + 1;
      rdy_cyc     = cyc;
      data_at_rdy = rx_data;
      pwr_at_rdy  = pwr_up;
    end
    if (frm_err) frm_count = frm_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rdy_count = 0;
    frm_count = 0;
  endtask

  // Send one frame. The start bit is 0, followed by data bits LSB first and
  // then the stop bit. The line is then held idle for one bit time.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      repeat (B) @(posedge clk);
      #1;
    end
    RX = 1'b1;
    repeat (B) @(posedge clk);
    #1;
    $display("tx byte=0x%02h stop=%0b rdy_pulses=%0d frm_err_pulses=%0d rx_data=0x%02h pwr_up=%0b",
             data, stop_bit, rdy_count, frm_count, rx_data, pwr_up);
  endtask

  // Send a good byte and check one rdy pulse, its latency, and the data.
  task automatic send_and_check(input string tag, input logic [7:0] data);
    int lat;
    clear_mon();
    send_byte(data, 1'b1);
    lat = rdy_cyc - start_cyc;
    check({tag, "_rdy_count"}, rdy_count, 1);
    check({tag, "_frm_count"}, frm_count, 0);
    check({tag, "_latency_ok"}, 32'((lat >= LAT_LO) && (lat <= LAT_HI)), 1);
    check({tag, "_data"}, data_at_rdy, data);
  endtask

  initial begin
    int bad;
    logic [7:0] g_byte;

    // Reset and idle
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (rdy !== 1'b0 || frm_err !== 1'b0 || pwr_up !== 1'b0 || rx_data !== 8'h00) bad++;
    end
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_pwr_up", pwr_up, 0);
    check("reset_idle_hold_bad_cycles", bad, 0);

    // Go command
    send_and_check("go1", 8'h67);
    check("go1_pwr_at_rdy", pwr_at_rdy, 0);
    check("go1_pwr_after", pwr_after, 1);

    // Stop with the rider on: the FSM goes to DSCN and power stays on
    send_and_check("stop_on", 8'h73);
    check("stop_on_pwr_after", pwr_after, 1);
    @(posedge clk); #1 rider_off = 1'b1;
    @(negedge clk);
    check("dscn_pwr_before_edge", pwr_up, 1);
    @(negedge clk);
    check("dscn_rider_off_pwr", pwr_up, 0);
    @(posedge clk); #1 rider_off = 1'b0;

    // Go again, then stop with the rider already off
    send_and_check("go2", 8'h67);
    check("go2_pwr_after", pwr_after, 1);
    @(posedge clk); #1 rider_off = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pwrd_rider_off_ignored", pwr_up, 1);
    send_and_check("stop_off", 8'h73);
    check("stop_off_pwr_at_rdy", pwr_at_rdy, 1);
    check("stop_off_pwr_after", pwr_after, 0);
    @(posedge clk); #1 rider_off = 1'b0;

    // An irrelevant byte while OFF
    send_and_check("irrelevant", 8'h41);
    check("irrelevant_pwr", pwr_up, 0);

    // A framing error on a 'g' frame
    clear_mon();
    send_byte(8'h67, 1'b0);
    check("frm_err_count", frm_count, 1);
    check("frm_err_rdy_count", rdy_count, 0);
    check("frm_err_rx_data", rx_data, 8'h41);
    check("frm_err_pwr", pwr_up, 0);

    // Reset mid-byte: start bit plus 3 data bits of 0x67, then reset
    clear_mon();
    g_byte = 8'h67;
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (B) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 RX = g_byte[i];
      repeat (B) @(posedge clk);
    end
    #1 rst_n = 1'b0;
    RX = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * B) @(posedge clk);
    @(negedge clk);
    check("midreset_rdy_count", rdy_count, 0);
    check("midreset_rx_data", rx_data, 8'h00);
    send_and_check("after_reset_go", 8'h67);
    check("after_reset_pwr", pwr_up, 1);

`ifdef RX_GLITCH_FILTER_EN
    // A short low pulse on the line
    clear_mon();
    @(posedge clk); #1 RX = 1'b0;
    repeat (400) @(posedge clk);
    #1 RX = 1'b1;
    repeat (2 * B) @(posedge clk);
    @(negedge clk);
    $display("glitch 400 clocks rdy_pulses=%0d frm_err_pulses=%0d", rdy_count, frm_count);
    check("glitch_rdy_count", rdy_count, 0);
    check("glitch_frm_count", frm_count, 0);
    check("glitch_rx_data", rx_data, 8'h67);
    check("glitch_pwr", pwr_up, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
